detector_jogada: RTL and testbench
==================================

DETECTOR_JOGADA -- requirements
Module: detector_jogada

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 5000, meaning: consecutive stable synchronized cycles required to accept a press or a release; legal range 1 to 65535.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; reset=0 forces the reset state immediately, independent of clock.
REQ-004 botoes  input  4  raw, asynchronous player buttons; 1=pressed.
REQ-005 habilita  input  1  game accepts a play (control unit waiting for jogada).
REQ-006 jogada  output  1  one-cycle pulse: debounced play accepted.
REQ-007 jogada_valor  output  4  registered button code of the last accepted play.
REQ-008 invalida  output  1  one-cycle pulse: debounced press rejected as non-one-hot.
REQ-009 db_estado  output  3  current FSM state code, for the 7-segment debug display.

Function
REQ-010 botoes SHALL pass through a 2-flop synchronizer (s1, s2); the FSM SHALL observe s2 only.
REQ-011 States and db_estado codes SHALL be: OCIOSO=0, FILTRA_PRESS=1, PULSO=2, ESPERA_SOLTA=3, FILTRA_SOLTA=4, REJEITA=5; an unused code SHALL return to OCIOSO on the next edge.
REQ-012 OCIOSO: s2!=0 -> capture s2 into cap, cnt=0, go FILTRA_PRESS; else stay.
REQ-013 FILTRA_PRESS: s2==0 -> OCIOSO; nonzero s2!=cap -> recapture, cnt=0, stay; s2==cap and cnt<DEBOUNCE_CYCLES-1 -> cnt+1; s2==cap and cnt==DEBOUNCE_CYCLES-1 -> acceptance.
REQ-014 Acceptance with habilita=1 -> PULSO and jogada_valor<=cap; with habilita=0 -> ESPERA_SOLTA, no pulse, jogada_valor unchanged (press discarded).
REQ-015 PULSO: jogada=1 for exactly this one cycle; unconditionally go ESPERA_SOLTA.
REQ-016 ESPERA_SOLTA: s2==0 -> cnt=0, go FILTRA_SOLTA; else stay.
REQ-017 FILTRA_SOLTA: s2!=0 -> ESPERA_SOLTA; s2==0 and cnt==DEBOUNCE_CYCLES-1 -> OCIOSO; else cnt+1.
REQ-018 Press-to-pulse latency SHALL be exactly DEBOUNCE_CYCLES+3 rising edges after botoes becomes stable.
REQ-019 cnt SHALL be 16 bits wide, SHALL never wrap, and SHALL only be compared against DEBOUNCE_CYCLES-1.
REQ-020 A held button SHALL produce exactly one jogada; a new jogada requires a full debounced release.
REQ-021 habilita SHALL be sampled only at acceptance; changes at other times have no effect.
REQ-022 jogada and invalida SHALL never be asserted in the same cycle.

Reset
REQ-023 reset=0 SHALL set: state=OCIOSO, s1=s2=0, cap=0, cnt=0, jogada=0, jogada_valor=0, invalida=0, db_estado=0.
REQ-024 Reset asserted mid-filter or mid-pulse SHALL abort the operation with no pulse emitted; after release a held button SHALL be debounced from scratch.

Configuration
REQ-025 Macro DETECTOR_JOGADA_ONEHOT_EN defined: at acceptance a cap with more than one bit set SHALL go to REJEITA, which pulses invalida for one cycle and then goes to ESPERA_SOLTA; habilita is ignored and jogada_valor is unchanged.
REQ-026 Macro undefined: any nonzero cap SHALL be accepted per REQ-014, REJEITA SHALL be unreachable, and invalida SHALL be constant 0.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Reset, habilita=1, botoes=0010 held -> single jogada pulse exactly 7 edges later; jogada_valor=0010; db_estado sequence 0,1,2,3.
REQ-028 botoes=0100 with bouncing to 0000 every 2 cycles for 10 cycles, then stable -> no pulse during bounce; exactly one pulse 7 edges after stable; jogada_valor=0100.
REQ-029 botoes=0001 held 50 cycles, released, pressed again -> exactly two pulses; the second press is not accepted until 4 stable-zero cycles have elapsed.
REQ-030 habilita=0 at acceptance of botoes=1000 -> jogada stays 0, jogada_valor keeps its previous value, state goes to 3.
REQ-031 reset pulsed low at edge 5 of a held press -> outputs zero immediately; after release the pulse comes 7 edges later.
REQ-032 With the macro defined, botoes=0011 -> invalida pulses once, jogada=0, db_estado shows 5; with the macro undefined -> jogada pulses and jogada_valor=0011.

Source files
------------

// File: rtl/detector_jogada.sv
// detector_jogada: synchronizes and debounces four player buttons, then emits one play pulse per debounced press.
// Optional build macro DETECTOR_JOGADA_ONEHOT_EN: rejects multi-button presses through REJEITA / invalida.
module detector_jogada #(
    parameter int DEBOUNCE_CYCLES = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes,
    input  logic       habilita,
    output logic       jogada,
    output logic [3:0] jogada_valor,
    output logic       invalida,
    output logic [2:0] db_estado
);

    typedef enum logic [2:0] {
        OCIOSO       = 3'd0,
        FILTRA_PRESS = 3'd1,
        PULSO        = 3'd2,
        ESPERA_SOLTA = 3'd3,
        FILTRA_SOLTA = 3'd4,
        REJEITA      = 3'd5
    } estado_t;

    localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

    estado_t     estado, estado_next;
    logic [3:0]  s1, s2;
    logic [3:0]  cap, cap_next;
    logic [3:0]  valor_next;
    logic [15:0] cnt, cnt_next;
    logic        rejeita_cap;

`ifdef DETECTOR_JOGADA_ONEHOT_EN
    assign rejeita_cap = (cap & (cap - 4'd1)) != 4'd0;
`else
    assign rejeita_cap = 1'b0;
`endif

    // Two-flop synchronizer; the FSM only ever looks at s2.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= 4'd0;
            s2 <= 4'd0;
        end else begin
            s1 <= botoes;
            s2 <= s1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado       <= OCIOSO;
            cap          <= 4'd0;
            cnt          <= 16'd0;
            jogada_valor <= 4'd0;
        end else begin
            estado       <= estado_next;
            cap          <= cap_next;
            cnt          <= cnt_next;
            jogada_valor <= valor_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block is given a hold value first, so no path can infer a latch.
        estado_next = estado;
        cap_next    = cap;
        cnt_next    = cnt;
        valor_next  = jogada_valor;
        case (estado)
            OCIOSO: begin
                if (s2 != 4'd0) begin
                    cap_next    = s2;
                    cnt_next    = 16'd0;
                    estado_next = FILTRA_PRESS;
                end
            end
            FILTRA_PRESS: begin
                if (s2 == 4'd0) begin
                    estado_next = OCIOSO;
                end else if (s2 != cap) begin
                    cap_next = s2;
                    cnt_next = 16'd0;
                end else if (cnt < CNT_MAX) begin
                    cnt_next = cnt + 16'd1;
                end else if (rejeita_cap) begin
                    estado_next = REJEITA;
                end else if (habilita) begin
                    valor_next  = cap;
                    estado_next = PULSO;
                end else begin
                    // Press accepted while the game is not waiting: discard it but still demand a release.
                    estado_next = ESPERA_SOLTA;
                end
            end
            PULSO, REJEITA: estado_next = ESPERA_SOLTA;
            ESPERA_SOLTA: begin
                if (s2 == 4'd0) begin
                    cnt_next    = 16'd0;
                    estado_next = FILTRA_SOLTA;
                end
            end
            FILTRA_SOLTA: begin
                if (s2 != 4'd0) begin
                    estado_next = ESPERA_SOLTA;
                end else if (cnt == CNT_MAX) begin
                    estado_next = OCIOSO;
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            default: estado_next = OCIOSO;
        endcase
    end

    assign jogada    = (estado == PULSO);
    assign db_estado = estado;
`ifdef DETECTOR_JOGADA_ONEHOT_EN
    assign invalida  = (estado == REJEITA);
`else
    assign invalida  = 1'b0;
`endif

endmodule

// File: tb/tb_detector_jogada.sv
// tb_detector_jogada: directed scenarios plus random button traffic, checked each cycle against a run-length model.
module tb_detector_jogada;

    localparam int D = 4;
`ifdef DETECTOR_JOGADA_ONEHOT_EN
    localparam bit ONEHOT = 1'b1;
`else
    localparam bit ONEHOT = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] botoes;
    logic       habilita;
    logic       jogada;
    logic [3:0] jogada_valor;
    logic       invalida;
    logic [2:0] db_estado;

    detector_jogada #(.DEBOUNCE_CYCLES(D)) dut (
        .clock        (clock),
        .reset        (reset),
        .botoes       (botoes),
        .habilita     (habilita),
        .jogada       (jogada),
        .jogada_valor (jogada_valor),
        .invalida     (invalida),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;
    int pulses   = 0;

    // Reference model: a press is a run of D+1 equal nonzero synchronized samples,
    // a release is a run of D+1 zero samples; the pulse/reject cycle ignores the buttons.
    typedef enum {ARMED, PULSING, REJECTING, RELEASING} mode_t;
    mode_t      m_mode;
    logic [3:0] m_s1, m_s2, m_run_val, m_valor;
    int         m_run, m_zrun;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode    = ARMED;
        m_s1      = 4'd0;
        m_s2      = 4'd0;
        m_run_val = 4'd0;
        m_valor   = 4'd0;
        m_run     = 0;
        m_zrun    = 0;
    endtask

    task automatic model_edge();
        logic [3:0] s;
        s = m_s2;
        case (m_mode)
            ARMED: begin
                if (s == 4'd0) m_run = 0;
                else if (m_run > 0 && s == m_run_val) m_run++;
                else begin
                    m_run_val = s;
                    m_run     = 1;
                end
                if (m_run == D + 1) begin
                    m_run = 0;
                    if (ONEHOT && $countones(m_run_val) > 1) m_mode = REJECTING;
                    else if (habilita) begin
                        m_valor = m_run_val;
                        m_mode  = PULSING;
                    end else begin
                        m_mode = RELEASING;
                        m_zrun = 0;
                    end
                end
            end
            PULSING, REJECTING: begin
                m_mode = RELEASING;
                m_zrun = 0;
            end
            RELEASING: begin
                if (s == 4'd0) m_zrun++;
                else m_zrun = 0;
                if (m_zrun == D + 1) begin
                    m_mode = ARMED;
                    m_run  = 0;
                end
            end
        endcase
        m_s2 = m_s1;
        m_s1 = botoes;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
        check("jogada", 32'(jogada), 32'(m_mode == PULSING));
        check("invalida", 32'(invalida), 32'(m_mode == REJECTING));
        check("jogada_valor", 32'(jogada_valor), 32'(m_valor));
        if (jogada === 1'b1) pulses++;
    endtask

    task automatic wait_pulse(input int max_edges, output int edges);
        edges = -1;
        for (int i = 1; i <= max_edges; i++) begin
            tick();
            if (jogada === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic release_all();
        botoes = 4'd0;
        repeat (D + 6) tick();
    endtask

    initial begin
        logic [2:0] exp_seq [8];
        int e;
        exp_seq = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3};

        reset    = 1'b0;
        botoes   = 4'd0;
        habilita = 1'b0;
        model_reset();
        #12;
        check("rst_jogada", 32'(jogada), 32'd0);
        check("rst_valor", 32'(jogada_valor), 32'd0);
        check("rst_invalida", 32'(invalida), 32'd0);
        check("rst_estado", 32'(db_estado), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Clean held press: state walk and pulse 7 edges after botoes settles.
        habilita = 1'b1;
        botoes   = 4'b0010;
        pulses   = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("seq_estado", 32'(db_estado), 32'(exp_seq[i]));
        end
        check("clean_pulses", 32'(pulses), 32'd1);
        check("clean_valor", 32'(jogada_valor), 32'd2);
        release_all();
        check("idle_after_release", 32'(db_estado), 32'd0);

        // Bouncing press.
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            botoes = ((k / 2) % 2 == 1) ? 4'b0000 : 4'b0100;
            tick();
        end
        check("bounce_pulses", 32'(pulses), 32'd0);
        botoes = 4'b0100;
        wait_pulse(20, e);
        check("bounce_latency", 32'(e), 32'd7);
        check("bounce_valor", 32'(jogada_valor), 32'd4);
        release_all();

        // Long hold, short release, full release.
        pulses = 0;
        botoes = 4'b0001;
        repeat (50) tick();
        check("hold_pulses", 32'(pulses), 32'd1);
        botoes = 4'b0000;
        repeat (3) tick();
        botoes = 4'b0001;
        repeat (15) tick();
        check("short_release_pulses", 32'(pulses), 32'd1);
        botoes = 4'b0000;
        repeat (8) tick();
        botoes = 4'b0001;
        wait_pulse(20, e);
        check("repress_latency", 32'(e), 32'd7);
        check("repress_pulses", 32'(pulses), 32'd2);
        release_all();

        // Acceptance while the game is not waiting for a play.
        pulses   = 0;
        habilita = 1'b0;
        botoes   = 4'b1000;
        repeat (7) tick();
        check("disabled_estado", 32'(db_estado), 32'd3);
        check("disabled_valor", 32'(jogada_valor), 32'd1);
        habilita = 1'b1;
        repeat (5) tick();
        check("disabled_pulses", 32'(pulses), 32'd0);
        release_all();

        // Reset in the middle of a held press.
        pulses = 0;
        botoes = 4'b0010;
        repeat (5) tick();
        reset = 1'b0;
        #1;
        check("midrst_jogada", 32'(jogada), 32'd0);
        check("midrst_valor", 32'(jogada_valor), 32'd0);
        check("midrst_estado", 32'(db_estado), 32'd0);
        model_reset();
        reset = 1'b1;
        wait_pulse(20, e);
        check("midrst_latency", 32'(e), 32'd7);
        check("midrst_pulses", 32'(pulses), 32'd1);
        release_all();

        // Two buttons at once.
        botoes = 4'b0011;
        repeat (7) tick();
        if (ONEHOT) begin
            check("multi_invalida", 32'(invalida), 32'd1);
            check("multi_estado", 32'(db_estado), 32'd5);
            check("multi_jogada", 32'(jogada), 32'd0);
        end else begin
            check("multi_jogada", 32'(jogada), 32'd1);
            check("multi_valor", 32'(jogada_valor), 32'd3);
        end
        tick();
        check("multi_after_estado", 32'(db_estado), 32'd3);
        release_all();

        // Random button traffic with random habilita.
        for (int seg = 0; seg < 250; seg++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 3);
            if (kind == 0) botoes = 4'd0;
            else if (kind == 1) botoes = 4'(1 << $urandom_range(0, 3));
            else botoes = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 12);
            for (int c = 0; c < len; c++) begin
                habilita = ($urandom_range(0, 3) != 0);
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
